// File: rtl/frame_bank_scheduler_if.sv
// rtl/frame_bank_scheduler_if.sv - single-port frame RAM bus between scheduler and RAM
//   mem_addr  [ADDR_W:0]   RAM word address, MSB selects the bank
//   mem_we                 RAM write enable
//   mem_wdata [DATA_W-1:0] RAM write data
//   mem_rdata [DATA_W-1:0] RAM read data, one cycle after mem_addr
//   modport master: scheduler side; modport slave: RAM side
interface frame_bank_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - double-buffered frame store: serial fill of back bank, display reads from front bank
//   CLK_40, rst             clock, asynchronous active-high reset
//   wr_start                start of a frame payload
//   wr_bit_valid, wr_bit    serial payload, MSB of each word first
//   vsync                   display frame boundary
//   rd_req, rd_addr         display read of the front bank (read has priority)
//   rd_data, rd_valid       read word, one cycle after the grant
//   mem                     RAM bus (frame_bank_scheduler_if.master)
//   start_req               pulse asking the host for the next frame
//   front_bank              bank being displayed
//   wr_overrun              sticky: a deserialized word was dropped
//   repeat_count            vsyncs that found no complete back frame
//   Macro FRAME_BANK_STATS_EN enables repeat_count; otherwise it reads 0.
module frame_bank_scheduler #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int CELL_COUNT = 1200
) (
  input  logic                   CLK_40,
  input  logic                   rst,
  input  logic                   wr_start,
  input  logic                   wr_bit_valid,
  input  logic                   wr_bit,
  input  logic                   vsync,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  frame_bank_scheduler_if.master mem,
  output logic                   start_req,
  output logic                   front_bank,
  output logic                   wr_overrun,
  output logic [7:0]             repeat_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_COUNT - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shifted;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   hold_data;
  logic                hold_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic                boot;
  logic                rd_grant;
  logic                wr_grant;
  logic                last_commit;
  logic                swap;

  // State register
  always_ff @(posedge CLK_40 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and RAM arbitration. The RAM bus is combinational so a read
  // granted in this cycle returns data in the next one.
  always_comb begin
    state_d        = state_q;
    rd_grant       = 1'b0;
    wr_grant       = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_we     = 1'b0;
    mem.mem_wdata  = '0;

    if (!rst) begin
      if (rd_req) begin
        rd_grant     = 1'b1;
        mem.mem_addr = {front_bank, rd_addr};
      end else if (state_q == FILL && hold_valid && !wr_start) begin
        // A restart in the same cycle discards the held word instead of writing it
        wr_grant      = 1'b1;
        mem.mem_addr  = {~front_bank, wr_addr};
        mem.mem_we    = 1'b1;
        mem.mem_wdata = hold_data;
      end
    end

    last_commit = wr_grant && (wr_addr == LAST_ADDR);
    swap        = (state_q == FULL) && vsync;

    case (state_q)
      IDLE:    if (wr_start) state_d = FILL;
      FILL:    if (!wr_start && last_commit) state_d = FULL;
      FULL:    if (vsync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted    = shift_q << 1;
    shifted[0] = wr_bit;
  end

  // Deserializer, holding register, write address and status
  always_ff @(posedge CLK_40 or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      wr_addr    <= '0;
      front_bank <= 1'b0;
      rd_valid   <= 1'b0;
      wr_overrun <= 1'b0;
      start_req  <= 1'b0;
      boot       <= 1'b1;
    end else begin
      boot      <= 1'b0;
      start_req <= boot || swap;
      rd_valid  <= rd_grant;
      if (swap) front_bank <= ~front_bank;

      if (wr_grant) begin
        hold_valid <= 1'b0;
        if (!last_commit) wr_addr <= wr_addr + 1'b1;
      end

      if ((state_q == IDLE || state_q == FILL) && wr_start) begin
        wr_addr    <= '0;
        bit_cnt    <= '0;
        shift_q    <= '0;
        hold_valid <= 1'b0;
      end else if (state_q == FILL && wr_bit_valid) begin
        shift_q <= shifted;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          // The holding register counts as free if it drains this same cycle.
          // A word completing alongside the final write belongs to no frame.
          if (!last_commit) begin
            if (!hold_valid || wr_grant) begin
              hold_data  <= shifted;
              hold_valid <= 1'b1;
            end else begin
              wr_overrun <= 1'b1;
            end
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign rd_data = rd_valid ? mem.mem_rdata : '0;

`ifdef FRAME_BANK_STATS_EN
  logic [7:0] repeat_q;

  always_ff @(posedge CLK_40 or posedge rst) begin
    if (rst)
      repeat_q <= 8'd0;
    else if (vsync && state_q != FULL && repeat_q != 8'hFF)
      repeat_q <= repeat_q + 8'd1;
  end

  assign repeat_count = repeat_q;
`else
  assign repeat_count = 8'd0;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - directed self-checking bench for frame_bank_scheduler
`timescale 1ns/1ps
module tb_frame_bank_scheduler;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 11;
  localparam int CELL_COUNT = 4;
  localparam logic [ADDR_W:0] BANK1 = 12'h800;

`ifdef FRAME_BANK_STATS_EN
  localparam logic [7:0] EXP_REPEAT = 8'd3;
`else
  localparam logic [7:0] EXP_REPEAT = 8'd0;
`endif

  logic              CLK_40 = 1'b0;
  logic              rst;
  logic              wr_start = 1'b0;
  logic              wr_bit_valid = 1'b0;
  logic              wr_bit = 1'b0;
  logic              vsync = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              start_req;
  logic              front_bank;
  logic              wr_overrun;
  logic [7:0]        repeat_count;

  int checks = 0;
  int passed = 0;

  logic [DATA_W-1:0] ram [0:(1<<(ADDR_W+1))-1];
  logic [ADDR_W:0]   log_addr[$];
  logic [DATA_W-1:0] log_data[$];

  always #12.5 CLK_40 = ~CLK_40;

  frame_bank_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  frame_bank_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CELL_COUNT(CELL_COUNT)) dut (
    .CLK_40       (CLK_40),
    .rst          (rst),
    .wr_start     (wr_start),
    .wr_bit_valid (wr_bit_valid),
    .wr_bit       (wr_bit),
    .vsync        (vsync),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .mem          (mif),
    .start_req    (start_req),
    .front_bank   (front_bank),
    .wr_overrun   (wr_overrun),
    .repeat_count (repeat_count)
  );

  // Synchronous single-port RAM plus a log of every committed write
  always @(posedge CLK_40) begin
    if (mif.mem_we === 1'b1) begin
      ram[mif.mem_addr] <= mif.mem_wdata;
      log_addr.push_back(mif.mem_addr);
      log_data.push_back(mif.mem_wdata);
    end
    mif.mem_rdata <= ram[mif.mem_addr];
  end

  task automatic step();
    @(posedge CLK_40);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int b = DATA_W - 1; b >= 0; b--) begin
      wr_bit_valid = 1'b1;
      wr_bit = w[b];
      step();
    end
    wr_bit_valid = 1'b0;
    wr_bit = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b0;
    #2 rst = 1'b1;
    step(); step();
    checks++; if (front_bank !== 1'b0) $display("FAIL reset_front_bank: got %b want 0", front_bank); else passed++;
    checks++; if (start_req !== 1'b0) $display("FAIL reset_start_req: got %b want 0", start_req); else passed++;
    checks++; if ({mif.mem_we, mif.mem_addr, mif.mem_wdata} !== '0) $display("FAIL reset_mem_bus: got we=%b addr=%h wdata=%h want all 0", mif.mem_we, mif.mem_addr, mif.mem_wdata); else passed++;
    checks++; if ({rd_valid, rd_data, wr_overrun, repeat_count} !== '0) $display("FAIL reset_status: got rd_valid=%b rd_data=%h ovr=%b rep=%0d want all 0", rd_valid, rd_data, wr_overrun, repeat_count); else passed++;
    rst = 1'b0;
    step();
    checks++; if (start_req !== 1'b1) $display("FAIL boot_start_req: got %b want 1", start_req); else passed++;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (start_req === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL boot_single_pulse: got %0d extra pulses want 0", pulses); else passed++;
  endtask

  task automatic test_fill_swap();
    logic [DATA_W-1:0] words [4];
    int n0;
    words = '{16'hA5A5, 16'h0001, 16'h0002, 16'h0003};
    n0 = log_addr.size();
    wr_start = 1'b1; step(); wr_start = 1'b0;
    for (int i = 0; i < 4; i++) send_word(words[i]);
    step(); step();
    checks++; if (log_addr.size() !== n0 + 4) $display("FAIL fill_write_count: got %0d want %0d", log_addr.size() - n0, 4); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr.size() < n0 + i + 1) $display("FAIL fill_write_%0d: got none want addr=%h data=%h", i, BANK1 + i, words[i]);
      else if ({log_addr[n0+i], log_data[n0+i]} !== {BANK1 + 12'(i), words[i]})
        $display("FAIL fill_write_%0d: got addr=%h data=%h want addr=%h data=%h", i, log_addr[n0+i], log_data[n0+i], BANK1 + 12'(i), words[i]);
      else passed++;
    end
    checks++; if (front_bank !== 1'b0) $display("FAIL fill_front_before_vsync: got %b want 0", front_bank); else passed++;
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++; if (front_bank !== 1'b1) $display("FAIL swap_front_bank: got %b want 1", front_bank); else passed++;
    checks++; if (start_req !== 1'b1) $display("FAIL swap_start_req: got %b want 1", start_req); else passed++;
    step();
    checks++; if (start_req !== 1'b0) $display("FAIL swap_start_req_end: got %b want 0", start_req); else passed++;
  endtask

  task automatic test_read_arbitration();
    logic [DATA_W-1:0] front [4];
    logic [DATA_W-1:0] w;
    int n0;
    front = '{16'hA5A5, 16'h0001, 16'h0002, 16'h0003};
    w = 16'h3C5A;
    n0 = log_addr.size();
    wr_start = 1'b1; step(); wr_start = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_addr = 11'(i % 4);
      wr_bit_valid = (i < 16);
      wr_bit = (i < 16) ? w[15 - (i % 16)] : 1'b0;
      step();
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, front[i % 4]})
        $display("FAIL read_%0d: got valid=%b data=%h want valid=1 data=%h", i, rd_valid, rd_data, front[i % 4]);
      else passed++;
    end
    wr_bit_valid = 1'b0;
    checks++; if (log_addr.size() !== n0) $display("FAIL read_blocks_write: got %0d writes want 0", log_addr.size() - n0); else passed++;
    rd_req = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0) $display("FAIL read_valid_drop: got %b want 0", rd_valid); else passed++;
    checks++;
    if (log_addr.size() !== n0 + 1) $display("FAIL read_then_write: got %0d writes want 1", log_addr.size() - n0);
    else if ({log_addr[n0], log_data[n0]} !== {12'h000, w}) $display("FAIL read_then_write: got addr=%h data=%h want addr=000 data=%h", log_addr[n0], log_data[n0], w);
    else passed++;
  endtask

  task automatic test_overrun();
    int n0;
    checks++; if (wr_overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", wr_overrun); else passed++;
    n0 = log_addr.size();
    wr_start = 1'b1; step(); wr_start = 1'b0;
    rd_req = 1'b1; rd_addr = 11'd2;
    send_word(16'h1111);
    send_word(16'h2222);
    step();
    checks++; if (wr_overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", wr_overrun); else passed++;
    rd_req = 1'b0;
    step(); step(); step();
    checks++;
    if (log_addr.size() !== n0 + 1) $display("FAIL overrun_writes: got %0d writes want 1", log_addr.size() - n0);
    else if ({log_addr[n0], log_data[n0]} !== {12'h000, 16'h1111}) $display("FAIL overrun_writes: got addr=%h data=%h want addr=000 data=1111", log_addr[n0], log_data[n0]);
    else passed++;
  endtask

  task automatic test_repeat();
    for (int i = 0; i < 3; i++) begin
      vsync = 1'b1; step(); vsync = 1'b0; step();
    end
    checks++; if (front_bank !== 1'b1) $display("FAIL repeat_front_bank: got %b want 1", front_bank); else passed++;
    checks++; if (repeat_count !== EXP_REPEAT) $display("FAIL repeat_count: got %0d want %0d", repeat_count, EXP_REPEAT); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] words [4];
    int n0;
    words = '{16'h0BAD, 16'hCAFE, 16'hF00D, 16'h1234};
    n0 = log_addr.size();
    wr_start = 1'b1; step(); wr_start = 1'b0;
    for (int i = 0; i < 4; i++) send_word(words[i]);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr.size() < n0 + i + 1) $display("FAIL b2b_write_%0d: got none want addr=%h data=%h", i, i, words[i]);
      else if ({log_addr[n0+i], log_data[n0+i]} !== {12'(i), words[i]})
        $display("FAIL b2b_write_%0d: got addr=%h data=%h want addr=%h data=%h", i, log_addr[n0+i], log_data[n0+i], 12'(i), words[i]);
      else passed++;
    end
    send_word(16'hDEAD);
    step(); step();
    checks++; if (log_addr.size() !== n0 + 4) $display("FAIL full_ignores_bits: got %0d writes want 4", log_addr.size() - n0); else passed++;
    wr_start = 1'b1; vsync = 1'b1; step(); wr_start = 1'b0; vsync = 1'b0;
    checks++; if ({front_bank, start_req} !== 2'b01) $display("FAIL coincide_swap: got front=%b start_req=%b want front=0 start_req=1", front_bank, start_req); else passed++;
    send_word(16'h7777);
    step(); step();
    checks++; if (log_addr.size() !== n0 + 4) $display("FAIL coincide_start_ignored: got %0d writes want 4", log_addr.size() - n0); else passed++;
    checks++; if (repeat_count !== EXP_REPEAT) $display("FAIL b2b_repeat_count: got %0d want %0d", repeat_count, EXP_REPEAT); else passed++;
  endtask

  task automatic test_reset_midframe();
    int n0, pulses;
    logic [DATA_W-1:0] w;
    w = 16'h9E37;
    n0 = log_addr.size();
    wr_start = 1'b1; step(); wr_start = 1'b0;
    send_word(16'h4444);
    send_word(16'h5555);
    step(); step();
    checks++; if (log_addr.size() !== n0 + 2) $display("FAIL mid_pre_writes: got %0d writes want 2", log_addr.size() - n0); else passed++;
    for (int b = 15; b >= 8; b--) begin
      wr_bit_valid = 1'b1; wr_bit = w[b]; step();
    end
    rst = 1'b1;
    #1;
    checks++; if ({mif.mem_we, mif.mem_addr} !== '0) $display("FAIL mid_rst_bus: got we=%b addr=%h want 0", mif.mem_we, mif.mem_addr); else passed++;
    step();
    for (int b = 7; b >= 0; b--) begin
      wr_bit = w[b]; step();
    end
    wr_bit_valid = 1'b0;
    checks++; if ({front_bank, wr_overrun, repeat_count, start_req} !== '0) $display("FAIL mid_rst_state: got front=%b ovr=%b rep=%0d start=%b want all 0", front_bank, wr_overrun, repeat_count, start_req); else passed++;
    rst = 1'b0;
    step();
    checks++; if (start_req !== 1'b1) $display("FAIL mid_boot_start_req: got %b want 1", start_req); else passed++;
    pulses = 0;
    send_word(16'h6666);
    for (int i = 0; i < 3; i++) begin
      step();
      if (start_req === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL mid_boot_single_pulse: got %0d extra pulses want 0", pulses); else passed++;
    checks++; if (log_addr.size() !== n0 + 2) $display("FAIL mid_no_writes_after_rst: got %0d writes want 2", log_addr.size() - n0); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_swap();
    test_read_arbitration();
    test_overrun();
    test_repeat();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
